// File: rtl/round_seq_ctrl_if.sv
// round_seq_ctrl_if
// Command and control bundle between the top-level command side, the
// round_seq_ctrl sequencer and the round_func datapath.
//   master : command source. Drives start/abort/cfg_*. Observes status and
//            datapath controls.
//   slave  : the sequencer. Consumes commands. Drives status (ready/busy/done),
//            latched modes, outer_round and every round_func control input.
interface round_seq_ctrl_if;
  logic        start;
  logic        abort;
  logic [2:0]  cfg_alg_mode;
  logic        cfg_enc_dec;
  logic [2:0]  cfg_mode_ref;
  logic [3:0]  cfg_rounds;

  logic        ready;
  logic        busy;
  logic        done;
  logic [2:0]  alg_mode;
  logic        mode_enc_dec;
  logic [2:0]  mode_ref;
  logic [3:0]  outer_round;
  logic [15:0] EN_R;
  logic [47:0] sel;
  logic        EN_R_1;
  logic [2:0]  sel_1;
  logic        ReF_en;
  logic        ACC_src_x;
  logic [1:0]  ACC_src_y;
  logic        sel_op;

  modport master (
    output start, abort, cfg_alg_mode, cfg_enc_dec, cfg_mode_ref, cfg_rounds,
    input  ready, busy, done, alg_mode, mode_enc_dec, mode_ref, outer_round,
           EN_R, sel, EN_R_1, sel_1, ReF_en, ACC_src_x, ACC_src_y, sel_op
  );

  modport slave (
    input  start, abort, cfg_alg_mode, cfg_enc_dec, cfg_mode_ref, cfg_rounds,
    output ready, busy, done, alg_mode, mode_enc_dec, mode_ref, outer_round,
           EN_R, sel, EN_R_1, sel_1, ReF_en, ACC_src_x, ACC_src_y, sel_op
  );
endinterface

// File: rtl/round_seq_ctrl.sv
// round_seq_ctrl
// Sequencer for the round_func datapath. It accepts one block operation on
// start&ready and then runs LOAD -> {LT -> NLT -> WB} x N -> DONE.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : round_seq_ctrl_if.slave. It carries the command inputs (start,
//           abort, cfg_*), the status outputs (ready, busy, done), the latched
//           modes, outer_round, and the round_func controls (EN_R, sel, EN_R_1,
//           sel_1, ReF_en, ACC_src_x, ACC_src_y, sel_op).
// Every output is a register. Its value is decoded from the next state, so it
// matches the state the FSM occupies during that cycle.
module round_seq_ctrl #(
  parameter int unsigned LT_CYCLES = 4,  // 2..8
  parameter int unsigned NLT_LAT   = 2   // 1..4
) (
  input  logic             clk,
  input  logic             rst_n,
  round_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LT,
    S_NLT,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [2:0]  LT_LAST  = 3'(LT_CYCLES - 1);
  localparam logic [2:0]  NLT_LAST = 3'(NLT_LAT - 1);
  localparam logic [47:0] SEL_NTO  = {16{3'd1}};

  state_t      r_state, w_state;
  logic [2:0]  r_cnt, w_cnt;
  logic [3:0]  r_rnd, w_rnd;
  logic [3:0]  r_last, w_last;        // N'-1
  logic [2:0]  r_alg, w_alg;
  logic        r_enc, w_enc;
  logic [2:0]  r_mref, w_mref;

  logic        r_ready, r_busy, r_done;
  logic [3:0]  r_outer_round;
  logic [15:0] r_en_r;
  logic [47:0] r_sel;
  logic        r_en_r_1;
  logic [2:0]  r_sel_1;
  logic        r_ref_en, r_acc_x, r_sel_op;
  logic [1:0]  r_acc_y;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_rnd   = r_rnd;
    w_last  = r_last;
    w_alg   = r_alg;
    w_enc   = r_enc;
    w_mref  = r_mref;
    case (r_state)
      S_IDLE: begin
        // abort has no effect here, so start wins when both are high.
        if (bus.start) begin
          w_state = S_LOAD;
          w_alg   = bus.cfg_alg_mode;
          w_enc   = bus.cfg_enc_dec;
          w_mref  = bus.cfg_mode_ref;
          w_rnd   = '0;
          w_cnt   = '0;
          w_last  = (bus.cfg_rounds == 4'd0) ? 4'd0 : bus.cfg_rounds - 4'd1;
        end
      end
      S_LOAD: begin
        w_state = S_LT;
        w_cnt   = '0;
      end
      S_LT: begin
        if (r_cnt == LT_LAST) begin
          w_state = S_NLT;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 3'd1;
        end
      end
      S_NLT: begin
        if (r_cnt == NLT_LAST) begin
          w_state = S_WB;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 3'd1;
        end
      end
      S_WB: begin
        w_cnt = '0;
        if (r_rnd == r_last) begin
          w_state = S_DONE;
        end else begin
          w_rnd   = r_rnd + 4'd1;
          w_state = S_LT;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_rnd   = '0;
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_rnd   = '0;
      end
    endcase
    if (bus.abort && (r_state != S_IDLE)) begin
      w_state = S_IDLE;
      w_cnt   = '0;
      w_rnd   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rnd         <= '0;
      r_last        <= '0;
      r_alg         <= '0;
      r_enc         <= 1'b0;
      r_mref        <= '0;
      r_ready       <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_outer_round <= '0;
      r_en_r        <= '0;
      r_sel         <= '0;
      r_en_r_1      <= 1'b0;
      r_sel_1       <= '0;
      r_ref_en      <= 1'b0;
      r_acc_x       <= 1'b0;
      r_acc_y       <= '0;
      r_sel_op      <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_rnd         <= w_rnd;
      r_last        <= w_last;
      r_alg         <= w_alg;
      r_enc         <= w_enc;
      r_mref        <= w_mref;
      r_ready       <= (w_state == S_IDLE);
      r_busy        <= (w_state == S_LOAD) || (w_state == S_LT) ||
                       (w_state == S_NLT)  || (w_state == S_WB);
      r_done        <= (w_state == S_DONE);
      r_outer_round <= (w_state == S_IDLE) ? 4'd0 : w_rnd;
      r_en_r        <= ((w_state == S_LOAD) || (w_state == S_WB)) ? 16'hFFFF : 16'h0000;
      r_sel         <= (w_state == S_WB) ? SEL_NTO : 48'd0;
      r_en_r_1      <= (w_state == S_WB);
      r_sel_1       <= (w_state == S_WB) ? 3'd1 : 3'd0;
      r_ref_en      <= (w_state == S_LT);
      r_acc_x       <= (w_state == S_LT) ? w_cnt[0] : 1'b0;
      r_acc_y       <= (w_state == S_LT) ? w_cnt[1:0] : 2'd0;
      r_sel_op      <= (w_state == S_LT) ? w_enc : 1'b0;
    end
  end

  assign bus.ready        = r_ready;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.alg_mode     = r_alg;
  assign bus.mode_enc_dec = r_enc;
  assign bus.mode_ref     = r_mref;
  assign bus.outer_round  = r_outer_round;
  assign bus.EN_R         = r_en_r;
  assign bus.sel          = r_sel;
  assign bus.EN_R_1       = r_en_r_1;
  assign bus.sel_1        = r_sel_1;
  assign bus.ReF_en       = r_ref_en;
  assign bus.ACC_src_x    = r_acc_x;
  assign bus.ACC_src_y    = r_acc_y;
  assign bus.sel_op       = r_sel_op;

endmodule
